// File: rtl/bf_3_ser.sv
// Stage-3 radix-2 butterflies over a captured 8-point frame, streamed out serially
// in bit-reversed order with a valid/ready handshake.
module bf_3_ser #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] y0_re,
    input  logic signed [15:0] y1_re,
    input  logic signed [15:0] y2_re,
    input  logic signed [15:0] y3_re,
    input  logic signed [15:0] y4_re,
    input  logic signed [15:0] y5_re,
    input  logic signed [15:0] y6_re,
    input  logic signed [15:0] y7_re,
    input  logic signed [15:0] y0_im,
    input  logic signed [15:0] y1_im,
    input  logic signed [15:0] y2_im,
    input  logic signed [15:0] y3_im,
    input  logic signed [15:0] y4_im,
    input  logic signed [15:0] y5_im,
    input  logic signed [15:0] y6_im,
    input  logic signed [15:0] y7_im,
    input  logic               en,
    input  logic               ifft,
    output logic               in_ready,
    output logic signed [15:0] out_re,
    output logic signed [15:0] out_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_idx,
    output logic               out_last,
    output logic               sat_flag
);

    typedef enum logic [1:0] {StIdle, StCalc, StSend} state_e;

    localparam int unsigned PairBase [4]  = '{0, 1, 4, 5};
    localparam int unsigned SendOrder [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    state_e             state_q, state_d;
    logic               armed_q;
    logic signed [15:0] y_re [8];
    logic signed [15:0] y_im [8];
    logic signed [15:0] cap_re_q [8], cap_re_d [8];
    logic signed [15:0] cap_im_q [8], cap_im_d [8];
    logic               ifft_q, ifft_d;
    logic signed [15:0] buf_re_q [8], buf_re_d [8];
    logic signed [15:0] buf_im_q [8], buf_im_d [8];
    logic signed [15:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [2:0]         out_idx_q, out_idx_d;
    logic               in_ready_q, in_ready_d, sat_q, sat_d;

    logic signed [16:0] sum_re [8], sum_im [8];
    logic signed [15:0] z_re [8], z_im [8];
    logic [15:0]        clip;
    logic signed [16:0] a_re, a_im, b_re, b_im, br, bi;

    assign y_re = '{y0_re, y1_re, y2_re, y3_re, y4_re, y5_re, y6_re, y7_re};
    assign y_im = '{y0_im, y1_im, y2_im, y3_im, y4_im, y5_im, y6_im, y7_im};

    // Operands widened to 17 bits so negating -32768 yields +32768; sums fit exactly.
    always_comb begin
        sum_re = '{default: '0};
        sum_im = '{default: '0};
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; br = '0; bi = '0;
        for (int i = 0; i < 4; i++) begin
            a_re = {cap_re_q[PairBase[i]][15], cap_re_q[PairBase[i]]};
            a_im = {cap_im_q[PairBase[i]][15], cap_im_q[PairBase[i]]};
            b_re = {cap_re_q[PairBase[i] + 2][15], cap_re_q[PairBase[i] + 2]};
            b_im = {cap_im_q[PairBase[i] + 2][15], cap_im_q[PairBase[i] + 2]};
            br = b_re;
            bi = b_im;
            if (i % 2 == 1) begin
                br = ifft_q ? -b_im : b_im;
                bi = ifft_q ? b_re  : -b_re;
            end
            sum_re[PairBase[i]]     = a_re + br;
            sum_im[PairBase[i]]     = a_im + bi;
            sum_re[PairBase[i] + 2] = a_re - br;
            sum_im[PairBase[i] + 2] = a_im - bi;
        end
    end

    always_comb begin
        clip = '0;
        for (int k = 0; k < 8; k++) begin
            z_re[k] = sum_re[k][15:0];
            z_im[k] = sum_im[k][15:0];
            if (SAT_EN) begin
                if (sum_re[k] > 17'sd32767) begin
                    z_re[k] = 16'sh7fff; clip[2*k] = 1'b1;
                end else if (sum_re[k] < -17'sd32768) begin
                    z_re[k] = 16'sh8000; clip[2*k] = 1'b1;
                end
                if (sum_im[k] > 17'sd32767) begin
                    z_im[k] = 16'sh7fff; clip[2*k+1] = 1'b1;
                end else if (sum_im[k] < -17'sd32768) begin
                    z_im[k] = 16'sh8000; clip[2*k+1] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cap_re_d    = cap_re_q;
        cap_im_d    = cap_im_q;
        ifft_d      = ifft_q;
        buf_re_d    = buf_re_q;
        buf_im_d    = buf_im_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        in_ready_d  = in_ready_q;
        sat_d       = sat_q;
        unique case (state_q)
            StIdle: begin
                // armed_q blocks a capture on the edge that coincides with reset release.
                if (en && armed_q) begin
                    cap_re_d   = y_re;
                    cap_im_d   = y_im;
                    ifft_d     = ifft;
                    sat_d      = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = StCalc;
                end
            end
            StCalc: begin
                for (int k = 0; k < 8; k++) begin
                    buf_re_d[k] = z_re[SendOrder[k]];
                    buf_im_d[k] = z_im[SendOrder[k]];
                end
                out_re_d    = z_re[0];
                out_im_d    = z_im[0];
                out_valid_d = 1'b1;
                out_idx_d   = 3'd0;
                out_last_d  = 1'b0;
                sat_d       = |clip;
                state_d     = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    if (out_idx_q == 3'd7) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_idx_d   = 3'd0;
                        in_ready_d  = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        out_idx_d  = out_idx_q + 3'd1;
                        out_re_d   = buf_re_q[out_idx_d];
                        out_im_d   = buf_im_q[out_idx_d];
                        out_last_d = (out_idx_d == 3'd7);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            cap_re_q    <= '{default: '0};
            cap_im_q    <= '{default: '0};
            ifft_q      <= 1'b0;
            buf_re_q    <= '{default: '0};
            buf_im_q    <= '{default: '0};
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            in_ready_q  <= 1'b1;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= 1'b1;
            cap_re_q    <= cap_re_d;
            cap_im_q    <= cap_im_d;
            ifft_q      <= ifft_d;
            buf_re_q    <= buf_re_d;
            buf_im_q    <= buf_im_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            in_ready_q  <= in_ready_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_bf_3_ser.sv
// Randomized self-checking bench for bf_3_ser: saturating and wrapping builds side by side,
// compared against an integer model of the stage-3 butterflies and bit-reversed send order.
module tb_bf_3_ser;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] y_re [8];
    logic signed [15:0] y_im [8];
    logic               en, ifft, out_ready;

    logic               s_in_ready, s_valid, s_last, s_sat;
    logic signed [15:0] s_re, s_im;
    logic [2:0]         s_idx;
    logic               w_in_ready, w_valid, w_last, w_sat;
    logic signed [15:0] w_re, w_im;
    logic [2:0]         w_idx;

    int n_pass = 0;
    int n_checks = 0;
    int send_order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int m_re [8], m_im [8];
    int exp_sre [8], exp_sim [8], exp_wre [8], exp_wim [8];
    int exp_flag;

    always #5 clk = ~clk;

    bf_3_ser #(.SAT_EN(1'b1)) dut_sat (
        .clk(clk), .reset(reset),
        .y0_re(y_re[0]), .y1_re(y_re[1]), .y2_re(y_re[2]), .y3_re(y_re[3]),
        .y4_re(y_re[4]), .y5_re(y_re[5]), .y6_re(y_re[6]), .y7_re(y_re[7]),
        .y0_im(y_im[0]), .y1_im(y_im[1]), .y2_im(y_im[2]), .y3_im(y_im[3]),
        .y4_im(y_im[4]), .y5_im(y_im[5]), .y6_im(y_im[6]), .y7_im(y_im[7]),
        .en(en), .ifft(ifft), .in_ready(s_in_ready), .out_re(s_re), .out_im(s_im),
        .out_valid(s_valid), .out_ready(out_ready), .out_idx(s_idx), .out_last(s_last),
        .sat_flag(s_sat)
    );

    bf_3_ser #(.SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .reset(reset),
        .y0_re(y_re[0]), .y1_re(y_re[1]), .y2_re(y_re[2]), .y3_re(y_re[3]),
        .y4_re(y_re[4]), .y5_re(y_re[5]), .y6_re(y_re[6]), .y7_re(y_re[7]),
        .y0_im(y_im[0]), .y1_im(y_im[1]), .y2_im(y_im[2]), .y3_im(y_im[3]),
        .y4_im(y_im[4]), .y5_im(y_im[5]), .y6_im(y_im[6]), .y7_im(y_im[7]),
        .en(en), .ifft(ifft), .in_ready(w_in_ready), .out_re(w_re), .out_im(w_im),
        .out_valid(w_valid), .out_ready(out_ready), .out_idx(w_idx), .out_last(w_last),
        .sat_flag(w_sat)
    );

    task automatic chk(input string tag, input int obs, input int want);
        n_checks++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, want);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int wrap16(input int v);
        int r;
        r = (v + 4 * 65536) % 65536;
        if (r >= 32768) r -= 65536;
        return r;
    endfunction

    // Expected samples in transmit order, from the values on the inputs at capture.
    task automatic compute_model(input bit inv);
        exp_flag = 0;
        for (int k = 0; k < 8; k++) begin
            int e, p, ar, ai, br, bi, t, zr, zi;
            e  = send_order[k];
            p  = e & 5;
            ar = m_re[p];     ai = m_im[p];
            br = m_re[p + 2]; bi = m_im[p + 2];
            if (p % 2 == 1) begin
                t  = br;
                br = inv ? -bi : bi;
                bi = inv ? t : -t;
            end
            zr = (e & 2) ? ar - br : ar + br;
            zi = (e & 2) ? ai - bi : ai + bi;
            exp_sre[k] = clamp16(zr); exp_sim[k] = clamp16(zi);
            exp_wre[k] = wrap16(zr);  exp_wim[k] = wrap16(zi);
            if (exp_sre[k] != zr || exp_sim[k] != zi) exp_flag = 1;
        end
    endtask

    task automatic rand_inputs;
        for (int i = 0; i < 8; i++) begin
            int s;
            s = $urandom_range(0, 7);
            y_re[i] = (s == 0) ? -16'sd32768 : (s == 1) ? 16'sd32767 : 16'($urandom);
            s = $urandom_range(0, 7);
            y_im[i] = (s == 0) ? -16'sd32768 : (s == 1) ? 16'sd32767 : 16'($urandom);
        end
    endtask

    task automatic clear_inputs;
        for (int i = 0; i < 8; i++) begin
            y_re[i] = '0;
            y_im[i] = '0;
        end
    endtask

    // Called at a sample point with in_ready high; returns at the sample point after the frame.
    // rmode: 0 = ready held 1, 1 = ready 1,0,0,1 then 1, 2 = random ready.
    task automatic run_frame(input bit hold, input int rmode);
        int k, cyc;
        bit rdy;
        for (int i = 0; i < 8; i++) begin
            m_re[i] = y_re[i];
            m_im[i] = y_im[i];
        end
        compute_model(ifft);
        en = 1'b1;
        tick;
        if (!hold) en = 1'b0;
        ifft = ~ifft;
        if (hold) rand_inputs();
        chk("calc_valid", s_valid, 0);
        chk("calc_in_ready", s_in_ready, 0);
        tick;
        chk("first_valid", s_valid, 1);
        chk("sat_flag", s_sat, exp_flag);
        chk("wrap_sat_flag", w_sat, 0);
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 40) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = !(cyc == 1 || cyc == 2);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            chk("valid", s_valid, 1);
            chk("in_ready_busy", s_in_ready, 0);
            chk("idx", s_idx, k);
            chk("last", s_last, (k == 7) ? 1 : 0);
            chk("sat_re", s_re, exp_sre[k]);
            chk("sat_im", s_im, exp_sim[k]);
            chk("wrap_re", w_re, exp_wre[k]);
            chk("wrap_im", w_im, exp_wim[k]);
            if (hold) rand_inputs();
            if (rdy) k++;
            cyc++;
            tick;
        end
        if (k < 8) chk("transfer_timeout", k, 8);
        chk("valid_fall", s_valid, 0);
        chk("last_fall", s_last, 0);
        chk("in_ready_back", s_in_ready, 1);
        out_ready = 1'b1;
    endtask

    task automatic directed_037;
        clear_inputs();
        y_re[0] = 16'sd100;
        y_re[2] = 16'sd20;
        y_im[1] = 16'sd10;
        y_re[3] = 16'sd3;
        y_im[3] = 16'sd4;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        en = 1'b0;
        ifft = 1'b0;
        out_ready = 1'b1;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", s_valid, 0);
        chk("rst_re", s_re, 0);
        chk("rst_im", s_im, 0);
        chk("rst_idx", s_idx, 0);
        chk("rst_last", s_last, 0);
        chk("rst_sat", s_sat, 0);
        chk("rst_in_ready", s_in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        tick;
        tick;

        directed_037();
        ifft = 1'b0;
        run_frame(1'b0, 0);
        directed_037();
        ifft = 1'b1;
        run_frame(1'b0, 0);

        clear_inputs();
        y_re[0] = 16'sd32767; y_im[0] = -16'sd32768;
        y_re[2] = 16'sd1;     y_im[2] = -16'sd1;
        ifft = 1'b0;
        run_frame(1'b0, 0);
        directed_037();
        run_frame(1'b0, 0);

        directed_037();
        ifft = 1'b0;
        run_frame(1'b0, 1);

        for (int f = 0; f < 12; f++) begin
            rand_inputs();
            ifft = 1'($urandom_range(0, 1));
            run_frame((f >= 4 && f < 8), (f % 3 == 0) ? 0 : 2);
        end
        en = 1'b0;
        tick;

        rand_inputs();
        en = 1'b1;
        tick;
        en = 1'b0;
        tick;
        out_ready = 1'b1;
        tick;
        tick;
        tick;
        chk("pre_abort_idx", s_idx, 3);
        #3;
        reset = 1'b0;
        #1;
        chk("abort_valid", s_valid, 0);
        chk("abort_re", s_re, 0);
        chk("abort_im", s_im, 0);
        chk("abort_idx", s_idx, 0);
        chk("abort_last", s_last, 0);
        chk("abort_in_ready", s_in_ready, 1);
        chk("abort_wrap_re", w_re, 0);
        @(negedge clk);
        reset = 1'b1;
        tick;
        chk("post_rst_valid", s_valid, 0);
        chk("post_rst_in_ready", s_in_ready, 1);
        tick;
        chk("post_rst_valid2", s_valid, 0);

        rand_inputs();
        ifft = 1'b1;
        run_frame(1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bf_3_ser.md
BF_3_SER -- requirements
Module: bf_3_ser

Interface
REQ-001 SHALL have parameter: SAT_EN, 1, 1 = saturate stage-3 results to 16 bits; 0 = wrap (two's-complement truncate).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: y0_re..y7_re, y0_im..y7_im  input  16 each, signed  stage-2 results.
REQ-005 SHALL have port: en  input  1  stage-2 data valid (level; may stay high).
REQ-006 SHALL have port: ifft  input  1  0 = forward (-j twiddle), 1 = inverse (+j twiddle).
REQ-007 SHALL have port: in_ready  output  1  high when a frame can be captured.
REQ-008 SHALL have ports: out_re, out_im  output  16 each, signed  serial result sample.
REQ-009 SHALL have port: out_valid  output  1  out_re/out_im/out_idx valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts the sample.
REQ-011 SHALL have port: out_idx  output  3  index of the current sample within the frame (0..7).
REQ-012 SHALL have port: out_last  output  1  high with the 8th sample of a frame.
REQ-013 SHALL have port: sat_flag  output  1  at least one saturation in the current frame.

Function
REQ-014 SHALL use FSM states IDLE, CALC, SEND.
REQ-015 IDLE: in_ready=1; when en=1, SHALL capture all 16 inputs and ifft, then go to CALC.
REQ-016 CALC (exactly 1 cycle): SHALL compute z0..z7 into an 8-entry buffer, then go to SEND.
REQ-017 Butterflies SHALL pair (a,b) = (y_p, y_p+2) for p in {0,1,4,5}.
REQ-018 For p in {0,4}, SHALL use b' = b.
REQ-019 For p in {1,5}: forward SHALL use b' = (b_im, -b_re); inverse SHALL use b' = (-b_im, b_re).
REQ-020 SHALL compute z_p = a+b' and z_p+2 = a-b', at 17-bit precision per component.
REQ-021 SAT_EN=1: results SHALL clamp to [-32768, 32767]; any clamp sets sat_flag, cleared on the next capture.
REQ-022 SAT_EN=0: SHALL keep the low 16 bits; sat_flag stays 0.
REQ-023 Negating -32768 SHALL be done at 17 bits, yielding +32768 before saturation.
REQ-024 SEND: SHALL present buffer entries in order z0,z4,z2,z6,z1,z5,z3,z7 with out_idx = 0..7.
REQ-025 A sample SHALL transfer when out_valid && out_ready; on transfer, out_idx SHALL advance.
REQ-026 While out_valid=1 && out_ready=0, out_re/out_im/out_idx/out_last SHALL hold stable.
REQ-027 out_last SHALL equal (out_idx==7) && out_valid.
REQ-028 On transfer of out_idx=7, SHALL return to IDLE; out_valid SHALL fall the next cycle.
REQ-029 in_ready SHALL be 0 in CALC and SEND; en during these states SHALL be ignored (frame dropped, no queueing).
REQ-030 Latency: en sampled in cycle N -> first out_valid in cycle N+2; 8 samples in 8 cycles with out_ready held 1.
REQ-031 en held high continuously SHALL recapture on the first IDLE cycle after each frame; minimum frame period 10 cycles.
REQ-032 ifft change after capture SHALL NOT affect the frame in flight.
REQ-033 All outputs SHALL be registered; no combinational path from inputs to outputs except out_ready -> none (out_valid not dependent on out_ready).

Reset
REQ-034 reset low SHALL immediately force state IDLE, buffer/captures to 0, out_re=out_im=0, out_valid=0, out_idx=0, out_last=0, sat_flag=0, in_ready=1 (deassertion: in_ready high first edge after release).
REQ-035 Reset asserted mid-SEND SHALL abort the frame; no remaining samples emitted after release.
REQ-036 Capture SHALL NOT occur on the same edge reset is released.

Verification
REQ-037 Forward, y0=(100,0), y2=(20,0), y1=(0,10), y3=(3,4), others 0, out_ready=1 -> out z0=(120,0), z4=(0,0), z2=(80,0), z6=(0,0), z1=(4,7), z5=(0,0), z3=(-4,13), z7=(0,0); out_last with 8th; first valid at N+2.
REQ-038 Same stimulus with ifft=1 -> z1=(-4,13), z3=(4,7); other entries unchanged.
REQ-039 SAT_EN=1, y0=(32767,-32768), y2=(1,-1) -> z0=(32767,-32768), sat_flag=1; next clean frame clears sat_flag; SAT_EN=0 build -> z0=(-32768,32767).
REQ-040 out_ready toggled 1,0,0,1 during SEND -> outputs held while low, no sample skipped or repeated, 8 transfers total.
REQ-041 en held high -> frames back-to-back, inputs changed during SEND ignored; captures only in IDLE.
REQ-042 reset pulled low at out_idx=3 -> all outputs 0 asynchronously; after release, IDLE with in_ready=1 and no stale samples.
